// File: rtl/ev22_pkg.sv
// Shared definitions for the EV22 sequencer: FSM states, opcode class
// match constants and instruction-register field positions.
package ev22_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int OPC_HI = 23;
  localparam int OPC_LO = 16;
  localparam int RI_HI  = 9;
  localparam int RI_LO  = 5;
  localparam int RJ_HI  = 4;
  localparam int RJ_LO  = 0;

  localparam logic [7:0] JMP_MASK = 8'hF8;
  localparam logic [7:0] JMP_VAL  = 8'h20;
  localparam logic [7:0] JZE_MASK = 8'hF8;
  localparam logic [7:0] JZE_VAL  = 8'h28;
  localparam logic [7:0] JNE_MASK = 8'hF8;
  localparam logic [7:0] JNE_VAL  = 8'h30;
  localparam logic [7:0] JCY_MASK = 8'hF8;
  localparam logic [7:0] JCY_VAL  = 8'h38;
  localparam logic [7:0] BSR_MASK = 8'hFC;
  localparam logic [7:0] BSR_VAL  = 8'h1C;
  localparam logic [7:0] RET_MASK = 8'hFF;
  localparam logic [7:0] RET_VAL  = 8'h41;

  function automatic logic op_match(input logic [7:0] op,
                                    input logic [7:0] mask,
                                    input logic [7:0] val);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/ev22_return_stack.sv
// Subroutine return-address stack, RS_DEPTH entries of PW bits; push/pop take
// effect at the clock edge, dout shows the top entry combinationally.
module ev22_return_stack
  import ev22_pkg::*;
#(
  parameter int PW       = 10,
  parameter int RS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(RS_DEPTH);

  logic [PW-1:0] mem [RS_DEPTH];
  logic [AW:0]   sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = sp[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign full    = (sp == (AW+1)'(RS_DEPTH));
  assign empty   = (sp == '0);
  assign dout    = mem[top_idx];

  // Only the pointer is reset; stale entries are unreachable once sp is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/ev22_sequencer.sv
// EV22 instruction sequencer: fetch/exec/mem FSM, 2 cycles per instruction (3 for
// memory ops) with zero-wait memories; each missing imem/dmem ack stalls one cycle.
module ev22_sequencer
  import ev22_pkg::*;
#(
  parameter int PW       = 10,
  parameter int IW       = 24,
  parameter int RS_DEPTH = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] imem_addr,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [7:0]    opcode,
  output logic [4:0]    ri,
  output logic [4:0]    rj,
  input  logic          mr,
  input  logic          mw,
  output logic          dmem_req,
  input  logic          dmem_ack,
  input  logic          zero_i,
  input  logic          w15_i,
  input  logic          cy_i,
  output logic          exec_en,
  output logic [PW-1:0] pc,
  output logic          fault
);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ir;
  logic [PW-1:0] pc_nxt;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] x_fld;
  logic          commit;
  logic          rs_push;
  logic          rs_pop;
  logic          rs_full;
  logic          rs_empty;
  logic [PW-1:0] rs_dout;
  logic          is_jmp;
  logic          is_jze;
  logic          is_jne;
  logic          is_jcy;
  logic          is_bsr;
  logic          is_ret;
  logic          take_jump;
  logic          unused_ir;

  assign opcode    = ir[OPC_HI:OPC_LO];
  assign ri        = ir[RI_HI:RI_LO];
  assign rj        = ir[RJ_HI:RJ_LO];
  assign x_fld     = ir[PW-1:0];
  assign pc_inc    = pc + PW'(1);
  assign unused_ir = ^ir[OPC_LO-1:RI_HI+1];

  assign is_jmp = op_match(opcode, JMP_MASK, JMP_VAL);
  assign is_jze = op_match(opcode, JZE_MASK, JZE_VAL);
  assign is_jne = op_match(opcode, JNE_MASK, JNE_VAL);
  assign is_jcy = op_match(opcode, JCY_MASK, JCY_VAL);
  assign is_bsr = op_match(opcode, BSR_MASK, BSR_VAL);
  assign is_ret = op_match(opcode, RET_MASK, RET_VAL);

  assign take_jump = is_jmp | (is_jze & zero_i) | (is_jne & ~w15_i) | (is_jcy & cy_i);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    commit    = 1'b0;
    rs_push   = 1'b0;
    rs_pop    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        // Control-flow opcodes take priority so a stray mr/mw cannot divert them.
        if (is_bsr) begin
          if (rs_full) begin
            state_nxt = FAULT;
          end else begin
            rs_push = 1'b1;
            commit  = 1'b1;
            pc_nxt  = pc + x_fld;
          end
        end else if (is_ret) begin
          if (rs_empty) begin
            state_nxt = FAULT;
          end else begin
            rs_pop = 1'b1;
            commit = 1'b1;
            pc_nxt = rs_dout;
          end
        end else if (mr | mw) begin
          state_nxt = MEM;
        end else begin
          commit = 1'b1;
          pc_nxt = take_jump ? x_fld : pc_inc;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          commit    = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = FETCH;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= PW'(RESET_PC);
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && imem_ack) begin
        ir <= imem_data;
      end
    end
  end

  ev22_return_stack #(
    .PW       (PW),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk   (clk),
    .reset (reset),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pc_inc),
    .dout  (rs_dout),
    .full  (rs_full),
    .empty (rs_empty)
  );

  // Strobes are masked in the reset cycle so an abandoned access never commits.
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) & ~reset;
  assign dmem_req  = (state == MEM) & ~reset;
  assign exec_en   = commit & ~reset;
  assign fault     = (state == FAULT);

endmodule

// File: doc/ev22_sequencer.md
# ev22_sequencer

Instruction sequencer for the EV22 core: it fetches instruction words from program memory, holds them in the instruction register, and presents the opcode and register fields to the instruction decoder. It resolves jumps, subroutine calls and returns, and inserts data-memory wait states. It generates the single-cycle commit strobe that lets the datapath write registers, W and CY.

## Interface
Parameters:
- PW, 10, program-counter width
- IW, 24, instruction width: OPCODE = [23:16], Ri = [9:5], Rj = [4:0], X/S operand = [PW-1:0]
- RS_DEPTH, 4, return-stack depth, power of two
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  PW  fetch address (= pc)
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch done; imem_data valid this cycle
- imem_data  in  IW  instruction word
- opcode  out  8  IR[23:16], to decoder
- ri, rj  out  5 each  IR fields, to decoder
- mr, mw  in  1 each  decoder memory-read/write flags
- dmem_req  out  1  data access request
- dmem_ack  in  1  data access done
- zero_i, w15_i, cy_i  in  1 each  datapath flags (W==0, W[15], carry)
- exec_en  out  1  commit strobe; the datapath writes only when it is high
- pc  out  PW  current PC
- fault  out  1  return-stack overflow or underflow

## Operation
- Instruction classes are taken from `opcode`:
  - JMP 00100xxx
  - JZE 00101xxx
  - JNE 00110xxx
  - JCY 00111xxx
  - BSR 000111xx
  - RET 01000001
  - MOM 00010[0/1]xx is memory-class via `mr`/`mw`.
- FSM states: FETCH, EXEC, MEM, FAULT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack, IR <= imem_data and go to EXEC.
  - Otherwise hold.
- EXEC: the decoder outputs are valid in this state.
  - If mr|mw: go to MEM; exec_en stays 0.
  - Otherwise exec_en=1 for this cycle and PC is updated as follows.
  - JMP: pc <= X.
  - JZE: pc <= X if zero_i, else pc+1.
  - JNE: pc <= X if !w15_i, else pc+1.
  - JCY: pc <= X if cy_i, else pc+1.
  - BSR: push pc+1, then pc <= pc + S. S is the low PW bits, wrapping mod 2^PW.
  - RET: pop into pc.
  - All other opcodes: pc <= pc+1, wrapping mod 2^PW.
  - Next state is FETCH.
- MEM:
  - dmem_req=1 until dmem_ack.
  - In the ack cycle: exec_en=1, pc <= pc+1, go to FETCH.
  - dmem_req drops the cycle after the ack.
- Flags are sampled only in the EXEC cycle.
- Return stack:
  - Push onto a full stack: go to FAULT; the stack is unchanged.
  - Pop from an empty stack: go to FAULT; pc is unchanged.
- FAULT is terminal until reset:
  - fault=1, imem_req=0, dmem_req=0, exec_en=0, pc frozen.
- BSR and RET never raise mr/mw to the bus; the sequencer ignores `mr` for those opcodes.

## Timing
- Reset (sync, takes effect at the edge where reset=1):
  - state=FETCH, pc=RESET_PC, IR=0, stack pointer=0.
  - fault=0, exec_en=0, dmem_req=0.
  - imem_req=1 from the first cycle after reset.
- Reset mid-fetch or mid-MEM abandons the access:
  - Requests drop at that edge.
  - A late ack in the reset cycle is ignored.
- imem_ack may be high in the same cycle as imem_req (zero-wait memory).
- Throughput with zero-wait memories:
  - 2 cycles per non-memory instruction: FETCH then EXEC.
  - 3 cycles per MOM.
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle.
- exec_en is never high for more than one consecutive cycle.
- There is exactly one exec_en per retired instruction; none occur in FETCH or FAULT.
- The updated pc is visible in the cycle after EXEC (or after the MEM ack), which is the next FETCH address.
- Acks that arrive when no request is outstanding are ignored.

## Structure
- Shared package ev22_pkg:
  - opcode match constants (JMP/JZE/JNE/JCY/BSR/RET masks and values)
  - state enum
  - IR field bit positions
- Sub-module ev22_return_stack (RS_DEPTH × PW):
  - inputs push, pop, din
  - outputs dout, full, empty
  - synchronous reset clears the pointer only.

## Test plan
- Reset, zero-wait memories, program of 3 MOV opcodes at 0..2 -> imem_addr 0,1,2 on cycles 1,3,5; exec_en on cycles 2,4,6.
- JZE X=0x20 with zero_i=1, then with zero_i=0 at pc=5 -> pc=0x20, then pc=6; JCY/JNE checked the same way with cy_i and w15_i.
- MOM W,Y with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; one exec_en in the ack cycle; pc+1 after.
- BSR S=0x10 at pc=0x3F0 (PW=10) -> pc=0x000 after wrap, stack top=0x3F1; RET -> pc=0x3F1.
- 5 nested BSR with RS_DEPTH=4 -> fault=1 at the 5th; requests low and pc frozen until reset; RET on an empty stack after reset -> fault=1.
- Reset asserted while imem_ack is pending -> no IR load, pc=RESET_PC, new fetch the next cycle.
